// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the serial transmitter.
//   state_e    - transmitter FSM states
//   DATA_BITS  - payload bits per frame
//   START_LVL  - line level of the start bit
//   STOP_LVL   - line level of the stop bit (and the idle line)
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

endpackage

// File: rtl/serial_fifo.sv
// serial_fifo: synchronous FIFO with first-word-fall-through read port.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO)
//   push, din  - write din when push and not full
//   pop, dout  - dout is the head entry; pop discards it when not empty
//   full/empty - occupancy flags
// DEPTH must be a power of two (pointers wrap naturally); occupancy uses
// one extra bit so that full and empty are distinct.
module serial_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    // push+pop on one edge leaves occupancy unchanged
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
    mem_q <= mem_d;
  end

  assign dout  = mem_q[rd_q];
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/serial_tx.sv
// serial_tx: buffered 8N1 UART transmitter (8E1 with SERIAL_TX_PARITY_EN).
//   clk, rst  - clock, synchronous active-high reset (aborts frame, flushes FIFO)
//   tx_data   - byte to send, taken when tx_valid && tx_ready
//   tx_valid  - tx_data is presented
//   tx_ready  - FIFO can accept a byte (registered, independent of tx_valid)
//   tx        - serial line, idle high, driven straight from a flop
//   busy      - frame in progress or bytes queued
// Macro SERIAL_TX_PARITY_EN: adds an even parity bit between data and stop.
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKRATE  = 2_000_000,
  parameter int BAUDRATE = 9600,
  parameter int DEPTH    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy
);

  localparam int DIV = CLKRATE / BAUDRATE;
  localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          up_q, up_d;
`ifdef SERIAL_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  logic       push, pop, full, empty, tc;
  logic [7:0] head;

  serial_fifo #(.DEPTH(DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  // up_q holds tx_ready low through the reset edge and for nothing longer
  assign up_d     = 1'b1;
  assign tx_ready = up_q && !full;
  assign push     = tx_valid && tx_ready;
  assign tc       = (baud_q == BW'(DIV - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) baud_d = tc ? '0 : baud_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = START_LVL;
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      START: begin
        if (tc) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (tc) begin
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = STOP_LVL;
`endif
          end else begin
            // shift_q[0] is on the line; next bit is shift_q[1]
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        if (tc) begin
          state_d = STOP;
          tx_d    = STOP_LVL;
        end
      end
`endif
      STOP: begin
        if (tc) begin
          // chain straight into the next frame when data is waiting
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = START_LVL;
`ifdef SERIAL_TX_PARITY_EN
            par_d   = ^head;
`endif
          end else begin
            state_d = IDLE;
            tx_d    = STOP_LVL;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_LVL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_LVL;
      up_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      up_q    <= up_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE) || !empty;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;
  localparam int DIV   = 208;
  localparam int DEPTH = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx, busy;

  int total = 0;
  int bad   = 0;

  serial_tx dut (
    .clk      (clk),
    .rst      (rst),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx       (tx),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference: a queue of accepted bytes plus "which clock of which frame".
  byte unsigned mq[$];
  bit           m_act, m_up, m_acc;
  int           m_t, m_sz;
  logic [10:0]  m_bits;

  function automatic logic [10:0] frame_bits(input logic [7:0] d);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
`ifdef SERIAL_TX_PARITY_EN
    f[9] = ^d;
`endif
    return f;
  endfunction

  // Called once per clock, after the edge; inputs are those seen at the edge.
  task automatic model_step();
    if (rst) begin
      mq.delete();
      m_act = 0; m_t = 0; m_up = 0;
    end else begin
      m_sz  = mq.size();
      m_acc = tx_valid && m_up && (m_sz < DEPTH);
      if (m_act) begin
        m_t++;
        if (m_t == FL*DIV) m_act = 0;
      end
      if (!m_act && m_sz > 0) begin
        m_bits = frame_bits(mq.pop_front());
        m_act  = 1; m_t = 0;
      end
      if (m_acc) mq.push_back(tx_data);
      m_up = 1;
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t: got=%0h want=%0h", nm, $time, got, want);
    end
  endtask

  task automatic tick();
    logic e_tx;
    @(negedge clk);
    model_step();
    e_tx = m_act ? m_bits[m_t/DIV] : 1'b1;
    chk("tx", int'(tx), int'(e_tx));
    chk("busy", int'(busy), int'(m_act || mq.size() != 0));
    chk("tx_ready", int'(tx_ready), int'(m_up && mq.size() < DEPTH));
  endtask

  logic [10:0] lit;
  int acc, fell_at, acc6_edge, lows, e;

  initial begin
    // reset
    repeat (3) tick();
    chk("rst_tx", int'(tx), 1);
    chk("rst_rdy", int'(tx_ready), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 0;
    tick();
    chk("rdy_after_rst", int'(tx_ready), 1);

    // single 0x55 frame, hand-computed levels
`ifdef SERIAL_TX_PARITY_EN
    lit = 11'b10010101010;
`else
    lit = 11'b01010101010;
`endif
    tx_data = 8'h55; tx_valid = 1; tick(); tx_valid = 0;
    for (int c = 1; c <= FL*DIV; c++) begin
      tick();
      if (c == 1) chk("latency", int'(tx), 0);
      if ((c-1) % DIV == DIV/2)
        chk($sformatf("bit%0d", (c-1)/DIV), int'(tx), int'(lit[(c-1)/DIV]));
    end
    chk("busy_last_clk", int'(busy), 1);
    tick();
    chk("busy_after_frame", int'(busy), 0);

    // back-to-back burst 0x01..0x06 with tx_valid held
    acc = 0; fell_at = -1; acc6_edge = -1; lows = 0; e = 0;
    while (acc < 6 && e < 20000) begin
      logic r;
      tx_valid = 1; tx_data = 8'(acc + 1); r = tx_ready;
      tick();
      if (r) begin acc++; if (acc == 6) acc6_edge = e; end
      if (!tx_ready && fell_at < 0) fell_at = e;
      if (!busy) lows++;
      e++;
    end
    tx_valid = 0;
    chk("ready_fell_edge", fell_at, 4);
    chk("byte6_accept_edge", acc6_edge, 2 + FL*DIV);
    for (; e <= 6*FL*DIV; e++) begin
      tick();
      if (!busy) lows++;
    end
    chk("burst_no_gap", lows, 0);
    tick();
    chk("burst_done", int'(busy), 0);

    // reset mid-frame discards the frame and the queued byte
    tx_data = 8'hA3; tx_valid = 1; tick();
    tx_data = 8'h3C; tick(); tx_valid = 0;
    repeat (499) tick();
    rst = 1; tick();
    chk("abort_tx", int'(tx), 1);
    chk("abort_busy", int'(busy), 0);
    rst = 0;
    lows = 0;
    repeat (3000) begin tick(); if (!tx || busy) lows++; end
    chk("abort_no_frame", lows, 0);

    // randomized traffic at several offered loads
    for (int ph = 0; ph < 4; ph++) begin
      int pct;
      pct = (ph == 0) ? 90 : (ph == 1) ? 3 : (ph == 2) ? 50 : 15;
      for (int i = 0; i < 5000; i++) begin
        tx_valid = ($urandom_range(0, 99) < pct);
        tx_data  = 8'($urandom);
        tick();
      end
    end
    tx_valid = 0;
    for (int i = 0; i < 15000 && busy; i++) tick();
    chk("drain", int'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 The block SHALL have parameter CLKRATE, default 2_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 9600, meaning the serial bit rate in baud.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning the number of transmit FIFO entries (power of 2, minimum 2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port tx_data, input, 8 bits: byte to send.
REQ-007 The block SHALL have port tx_valid, input, 1 bit: tx_data is presented.
REQ-008 The block SHALL have port tx_ready, output, 1 bit: the FIFO can accept a byte.
REQ-009 The block SHALL have port tx, output, 1 bit: serial line, idle high.
REQ-010 The block SHALL have port busy, output, 1 bit: a frame is in progress or the FIFO is non-empty.

Function
REQ-011 The bit period SHALL be DIV = CLKRATE/BAUDRATE clocks, using truncating integer division (208 for the defaults).
REQ-012 A byte SHALL be accepted on any rising edge where tx_valid and tx_ready are both 1; tx_data is not sampled otherwise.
REQ-013 tx_ready SHALL equal "FIFO not full" and SHALL NOT depend combinationally on tx_valid.
REQ-014 The frame SHALL consist of 1 start bit (0), 8 data bits sent LSB first, an optional parity bit (REQ-026), and 1 stop bit (1); every bit is held for exactly DIV clocks.
REQ-015 The FSM SHALL have the states IDLE, START, DATA, PARITY, and STOP; PARITY SHALL be unreachable when parity is compiled out.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head entry into the shift register and enter START on the same edge.
REQ-017 Latency: when a byte is accepted at edge N into an empty FIFO while in IDLE, tx SHALL be 0 from edge N+1.
REQ-018 The FSM SHALL advance START->DATA, DATA(x8)->PARITY or STOP, and STOP->next state at each bit-counter terminal count (DIV-1).
REQ-019 At the end of STOP, the FSM SHALL pop and go directly to START if the FIFO is non-empty (no idle gap between frames), and go to IDLE otherwise.
REQ-020 A push and a pop on the same edge SHALL leave the occupancy unchanged and keep entry order; a push while full cannot occur because tx_ready is 0.
REQ-021 FIFO pointers SHALL wrap modulo DEPTH, and occupancy SHALL be tracked with log2(DEPTH)+1 bits so that full and empty can be distinguished.
REQ-022 tx SHALL be driven directly from a register, with no combinational glitch path.
REQ-023 busy SHALL be 1 whenever state != IDLE or occupancy != 0.

Reset
REQ-024 While rst is 1 at an edge: tx=1, tx_ready=0, busy=0, state=IDLE, bit and baud counters=0, FIFO empty. tx_ready SHALL return to 1 on the first edge after rst falls.
REQ-025 A reset during a frame SHALL abort the frame: tx is high from the next edge, and all queued bytes are discarded.

Configuration
REQ-026 With SERIAL_TX_PARITY_EN defined, the block SHALL insert an even-parity bit (XOR of the 8 data bits) between DATA and STOP, giving an 11-bit frame; without the macro, the frame SHALL be 10 bits and no parity logic SHALL be synthesised.

Structure
REQ-027 The shared package serial_pkg SHALL hold the FSM state enum, the DATA_BITS=8 constant, and the start/stop level constants.
REQ-028 The FIFO SHALL be a sub-module named serial_fifo (parameter DEPTH, with push, pop, full, and empty signals); baud timing and the FSM SHALL stay in serial_tx.

Verification
REQ-029 Defaults, parity off: push 0x55 -> tx is 0,1,0,1,0,1,0,1,0,1, with each level lasting 208 clocks; the frame is 2080 clocks, after which busy=0.
REQ-030 Parity on: push 0x07 -> data bits 1,1,1,0,0,0,0,0, then parity=1 and stop=1; the frame is 2288 clocks.
REQ-031 Hold tx_valid for bytes 0x01..0x06 on consecutive edges from edge 0 -> 0x01..0x05 are accepted and tx_ready falls after edge 4; 0x06 stalls until the pop at the end of frame 1, and all six frames are emitted back-to-back with no idle gap.
REQ-032 Push 0xA3 and assert rst at clock 500 of its frame -> tx=1 from the next edge, busy=0, and no further frame is emitted after rst releases.
REQ-033 Simultaneous push and pop with occupancy 2 -> occupancy stays 2 and the output byte order is preserved.
REQ-034 Push while full (tx_valid=1, tx_ready=0) -> the byte is not stored and the FIFO contents are unchanged.
